// File: rtl/pulse_period_meter_pkg.sv
// Shared constants for the pulse period meter: speed codes, rate constants,
// default decode thresholds, FSM state encoding and the period decoder.
package pulse_period_meter_pkg;

   localparam int unsigned WIDTH_DEFAULT = 28;

   localparam logic [1:0] SPD_FAST     = 2'b00;
   localparam logic [1:0] SPD_MED_FAST = 2'b01;
   localparam logic [1:0] SPD_MED_SLOW = 2'b10;
   localparam logic [1:0] SPD_SLOW     = 2'b11;

   // Divider periods used by the rate-select mux, one per speed code
   localparam int unsigned RATE_FAST     = 12_500_000;
   localparam int unsigned RATE_MED_FAST = 50_000_000;
   localparam int unsigned RATE_MED_SLOW = 100_000_000;
   localparam int unsigned RATE_SLOW     = 200_000_000;

   localparam int unsigned THR_01_DEFAULT = 25_000_000;
   localparam int unsigned THR_10_DEFAULT = 75_000_000;
   localparam int unsigned THR_11_DEFAULT = 150_000_000;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_e;

   // Map a measured period onto the speed code that would have produced it
   function automatic logic [1:0] decode_speed(input logic [31:0] p,
                                               input logic [31:0] thr_01,
                                               input logic [31:0] thr_10,
                                               input logic [31:0] thr_11);
      logic [1:0] code;
      if (p < thr_01)      code = SPD_FAST;
      else if (p < thr_10) code = SPD_MED_FAST;
      else if (p < thr_11) code = SPD_MED_SLOW;
      else                 code = SPD_SLOW;
      return code;
   endfunction

endpackage

// File: rtl/pulse_period_meter_if.sv
// Pulse input/enable and measurement result bundle of the pulse period meter.
interface pulse_period_meter_if #(
   parameter int unsigned WIDTH = 28
);
   logic             enable;
   logic             pulse_in;
   logic [WIDTH-1:0] period;
   logic [1:0]       speed_code;
   logic             valid;
   logic             overflow;
   logic             busy;

   modport master (
      input  enable, pulse_in,
      output period, speed_code, valid, overflow, busy
   );

   modport slave (
      output enable, pulse_in,
      input  period, speed_code, valid, overflow, busy
   );
endinterface

// File: rtl/pulse_period_meter_rise_detect.sv
// One-bit rising-edge detector; the previous-level register is the only state.
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic rise_c
);
   logic prev;

   always_ff @(posedge clock) begin
      if (reset) prev <= 1'b0;
      else       prev <= sig;
   end

   assign rise_c = sig & ~prev;
endmodule

// File: rtl/pulse_period_meter.sv
// Measures clocks between consecutive rising edges of pulse_in and decodes the
// period into a 2-bit speed code; a saturated count reports a timeout.
module pulse_period_meter
   import pulse_period_meter_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEFAULT,
   parameter int unsigned MAX_PERIOD = (2 ** WIDTH) - 1,
   parameter int unsigned THR_01     = THR_01_DEFAULT,
   parameter int unsigned THR_10     = THR_10_DEFAULT,
   parameter int unsigned THR_11     = THR_11_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   pulse_period_meter_if.master bus
);
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_PERIOD);
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [1:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             rise_c;

   rise_detect u_rise_detect (
      .clock  (clock),
      .reset  (reset),
      .sig    (bus.pulse_in),
      .rise_c (rise_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         code_q   <= SPD_FAST;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
      end
   end

   // Next state and next result; a rise takes priority over saturation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      code_d   = code_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;

      if (!bus.enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise_c) begin
                  state_d = MEASURE;
                  cnt_d   = CNT_ONE;
               end
            end
            MEASURE: begin
               if (rise_c) begin
                  period_d = cnt_q;
                  code_d   = decode_speed(32'(cnt_q), THR_01, THR_10, THR_11);
                  ovf_d    = 1'b0;
                  valid_d  = 1'b1;
                  cnt_d    = CNT_ONE;
               end else if (cnt_q == CNT_MAX) begin
                  period_d = CNT_MAX;
                  code_d   = SPD_SLOW;
                  ovf_d    = 1'b1;
                  valid_d  = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      busy_d = (state_d == MEASURE);
   end

   assign bus.period     = period_q;
   assign bus.speed_code = code_q;
   assign bus.valid      = valid_q;
   assign bus.overflow   = ovf_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter with small simulation parameters.
module tb_pulse_period_meter;
   localparam int unsigned WIDTH  = 6;
   localparam int unsigned MAXP   = 63;
   localparam int unsigned THR_01 = 5;
   localparam int unsigned THR_10 = 15;
   localparam int unsigned THR_11 = 30;

   typedef struct {
      int unsigned period;
      logic [1:0]  code;
      logic        ovf;
   } exp_t;

   logic clock;
   logic reset;
   exp_t sb[$];
   int   tests_run;
   int   tests_failed;

   pulse_period_meter_if #(.WIDTH(WIDTH)) bus ();

   pulse_period_meter #(
      .WIDTH(WIDTH), .MAX_PERIOD(MAXP),
      .THR_01(THR_01), .THR_10(THR_10), .THR_11(THR_11)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input int unsigned p, input logic [1:0] c, input logic o);
      exp_t e;
      e.period = p;
      e.code   = c;
      e.ovf    = o;
      sb.push_back(e);
   endtask

   // n rises spaced gap clocks apart; each captured rise expects one result
   task automatic pulses(input int gap, input int n, input logic [1:0] code);
      for (int i = 0; i < n; i++) begin
         if (i > 0) push_exp(gap, code, 1'b0);
         bus.pulse_in = 1'b1;
         tick();
         bus.pulse_in = 1'b0;
         repeat (gap - 1) tick();
      end
   endtask

   task automatic disarm();
      bus.enable = 1'b0;
      tick();
      tick();
      bus.enable = 1'b1;
   endtask

   // Compare every result strobe against the oldest pending expectation
   always @(negedge clock) begin
      if (!reset && bus.valid) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("period", 32'(bus.period), e.period);
            check_eq("speed_code", 32'(bus.speed_code), 32'(e.code));
            check_eq("overflow", 32'(bus.overflow), 32'(e.ovf));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      bus.enable   = 1'b0;
      bus.pulse_in = 1'b0;
      tick();
      tick();
      check_eq("rst_period", 32'(bus.period), 32'd0);
      check_eq("rst_code", 32'(bus.speed_code), 32'd0);
      check_eq("rst_valid", 32'(bus.valid), 32'd0);
      check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      reset      = 1'b0;
      bus.enable = 1'b1;
      tick();

      pulses(4, 3, 2'b00);  disarm();
      pulses(5, 2, 2'b01);  disarm();
      pulses(14, 2, 2'b01); disarm();
      pulses(15, 2, 2'b10); disarm();
      pulses(29, 2, 2'b10); disarm();
      pulses(30, 2, 2'b11); disarm();

      // Timeout: single rise then silence
      push_exp(MAXP, 2'b11, 1'b1);
      bus.pulse_in = 1'b1;
      tick();
      bus.pulse_in = 1'b0;
      repeat (70) tick();
      check_eq("timeout_busy", 32'(bus.busy), 32'd0);
      check_eq("timeout_ovf_hold", 32'(bus.overflow), 32'd1);
      // Next rise only rearms
      bus.pulse_in = 1'b1;
      tick();
      bus.pulse_in = 1'b0;
      repeat (3) tick();
      check_eq("rearm_busy", 32'(bus.busy), 32'd1);
      check_eq("rearm_period_hold", 32'(bus.period), MAXP);
      disarm();

      // Rise exactly at the saturation count is a normal result
      pulses(63, 2, 2'b11);
      check_eq("sat_rise_busy", 32'(bus.busy), 32'd1);
      check_eq("sat_rise_ovf", 32'(bus.overflow), 32'd0);
      disarm();

      // Reset mid-measure
      bus.pulse_in = 1'b1;
      tick();
      bus.pulse_in = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      tick();
      check_eq("midrst_period", 32'(bus.period), 32'd0);
      check_eq("midrst_code", 32'(bus.speed_code), 32'd0);
      check_eq("midrst_valid", 32'(bus.valid), 32'd0);
      check_eq("midrst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      tick();

      // Enable dropped mid-measure: results hold, no strobe
      pulses(7, 2, 2'b01);
      bus.enable = 1'b0;
      tick();
      tick();
      check_eq("endrop_period", 32'(bus.period), 32'd7);
      check_eq("endrop_code", 32'(bus.speed_code), 32'd1);
      check_eq("endrop_busy", 32'(bus.busy), 32'd0);
      bus.enable = 1'b1;
      tick();

      // Long high level counts as a single rise
      bus.pulse_in = 1'b1;
      repeat (20) tick();
      bus.pulse_in = 1'b0;
      repeat (5) tick();
      push_exp(25, 2'b10, 1'b0);
      bus.pulse_in = 1'b1;
      tick();
      bus.pulse_in = 1'b0;
      repeat (4) tick();
      disarm();

      repeat (3) tick();
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
